// File: rtl/tdm_scan_mux.sv
// tdm_scan_mux: registered N-to-1 mux with manual select and time-division auto-scan.
// Optional feature macro SCAN_MASK_EN adds a ch_mask port that restricts which channels are scanned.
module tdm_scan_mux #(
   parameter  int CHANNELS = 8,
   parameter  int WIDTH    = 1,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic [CHANNELS*WIDTH-1:0] ch_in,
`ifdef SCAN_MASK_EN
   input  logic [CHANNELS-1:0]       ch_mask,
`endif
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_valid,
   output logic [SEL_W-1:0]          ch_id,
   output logic                      frame_start
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [SEL_W-1:0]    r_scan_ptr;
   logic [SEL_W-1:0]    w_ptr_nx;
   logic [SEL_W-1:0]    w_first;
   logic [SEL_W-1:0]    w_succ;
   logic [SEL_W-1:0]    w_sel;
   logic [SEL_W-1:0]    w_id_nx;
   logic [CW-1:0]       r_dwell_cnt;
   logic [CW-1:0]       w_cnt_nx;
   logic [CHANNELS-1:0] w_mask;
   logic [WIDTH-1:0]    w_data;
   logic [WIDTH-1:0]    w_dout_nx;
   logic                w_any;
   logic                w_sel_ok;
   logic                w_enter;
   logic                w_wrap;
   logic                w_valid_nx;
   logic                w_fs_nx;

`ifdef SCAN_MASK_EN
   assign w_mask = ch_mask;
`else
   assign w_mask = '1;
`endif

   // with no channel enabled the scan stalls instead of producing samples
   assign w_any    = |w_mask;
   assign w_sel_ok = int'(sel_in) < CHANNELS;
   assign w_enter  = r_state != SCAN;
   assign w_wrap   = r_dwell_cnt == CW'(DWELL - 1);
   assign w_sel    = mode ? w_ptr_nx : sel_in;

   // lowest enabled channel, and the next enabled channel above scan_ptr (wrapping to the lowest)
   always_comb begin
      w_first = '0;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (w_mask[k]) w_first = SEL_W'(k);
      w_succ = w_first;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (w_mask[k] && SEL_W'(k) > r_scan_ptr) w_succ = SEL_W'(k);
   end

   // scan position of the next sample: restart on entry, advance after the last dwell cycle
   always_comb begin
      w_ptr_nx = r_scan_ptr;
      w_cnt_nx = r_dwell_cnt;
      if (en && mode && w_any) begin
         w_ptr_nx = w_enter ? w_first : (w_wrap ? w_succ : r_scan_ptr);
         w_cnt_nx = (w_enter || w_wrap) ? '0 : r_dwell_cnt + 1'b1;
      end
   end

   // channel data mux driven by either the manual select or the upcoming scan position
   always_comb begin
      w_data = '0;
      for (int k = 0; k < CHANNELS; k++)
         if (w_sel == SEL_W'(k)) w_data = ch_in[k*WIDTH +: WIDTH];
   end

   // next state and next registered outputs; disabled cycles hold data but drop valid and frame pulse
   always_comb begin
      w_state_nx = r_state;
      w_dout_nx  = dout;
      w_id_nx    = ch_id;
      w_valid_nx = 1'b0;
      w_fs_nx    = 1'b0;
      if (en && !mode) begin
         w_state_nx = MANUAL;
         w_dout_nx  = w_sel_ok ? w_data : '0;
         w_id_nx    = w_sel_ok ? sel_in : ch_id;
         w_valid_nx = w_sel_ok;
      end else if (en) begin
         w_state_nx = SCAN;
         if (w_any) begin
            w_dout_nx  = w_data;
            w_id_nx    = w_ptr_nx;
            w_valid_nx = 1'b1;
            w_fs_nx    = (w_ptr_nx == w_first) && (w_cnt_nx == '0);
         end
      end
   end

   // state and output registers; reset overrides enable and mode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_scan_ptr  <= '0;
         r_dwell_cnt <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         ch_id       <= '0;
         frame_start <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_scan_ptr  <= w_ptr_nx;
         r_dwell_cnt <= w_cnt_nx;
         dout        <= w_dout_nx;
         dout_valid  <= w_valid_nx;
         ch_id       <= w_id_nx;
         frame_start <= w_fs_nx;
      end
   end
endmodule
